palette_ram: RTL and testbench
==============================

# palette_ram

Parametrised dual-clock palette/colour RAM for the video path. The CPU writes and reads on port A (clk_a); the video pipeline reads on port B (clk_b). A built-in clear sequencer fills every entry with INIT_VAL after reset and on request, so contents are deterministic in hardware and not only in simulation. Port B has selectable read latency, and port A has selectable read-during-write behaviour.

## Interface
- DATA_W, 4: entry width in bits.
- ADDR_W, 4: address width. DEPTH = 2**ADDR_W.
- INIT_VAL, 0: fill value written by the clear sequencer.
- RD_LAT_B, 1: port B read latency in clk_b cycles. Legal values are 1 or 2.
- WRITE_FIRST, 0: port A read-during-write behaviour. 0 = read-first (old data), 1 = write-first (din_a).

- clk_a  in  1  port A / control clock.
- reset  in  1  synchronous, active-high; clock clk_a.
- clk_b  in  1  port B read clock.
- addr_a  in  ADDR_W  port A address.
- din_a  in  DATA_W  port A write data.
- we_n_a  in  1  port A write enable, active-low.
- dout_a  out  DATA_W  port A registered read data.
- clear_req  in  1  one-cycle pulse (clk_a) that starts a full clear.
- busy  out  1  high while the clear sequencer runs.
- clear_done  out  1  one-cycle pulse when a clear completes.
- addr_b  in  ADDR_W  port B address.
- dout_b  out  DATA_W  port B read data.

## Operation
- Storage is DEPTH x DATA_W. Only port A and the sequencer write it. Port B is read-only.
- FSM (clk_a) has two states, IDLE and CLEAR, plus a counter cnt of ADDR_W bits.
  - reset forces state CLEAR, cnt=0, busy=1, clear_done=0, dout_a=0.
  - In CLEAR, each clk_a edge with reset low writes INIT_VAL to ram[cnt] and increments cnt.
  - When the write hits cnt=DEPTH-1: next state is IDLE, busy<=0, clear_done<=1. cnt wraps to 0.
  - In IDLE, clear_req=1 moves to CLEAR with cnt=0 and busy<=1.
  - clear_req while already in CLEAR is ignored; the walk does not restart.
  - reset mid-clear restarts the walk at address 0.
- Port A writes: ram[addr_a]<=din_a when we_n_a=0, only in IDLE. Writes in CLEAR are dropped. If clear_req and we_n_a=0 coincide in IDLE, the clear wins and the write is dropped.
- Port A reads: dout_a<=ram[addr_a] every clk_a edge in IDLE.
  - During a port A write, dout_a gets the old data if WRITE_FIRST=0, or din_a if WRITE_FIRST=1.
  - While busy=1, dout_a<=INIT_VAL.
- Port B reset: reset passes through a 2-flop synchroniser into clk_b, giving rst_b. While rst_b=1, all port B pipeline registers and dout_b are held at 0.
- Port B reads:
  - RD_LAT_B=1: dout_b<=ram[addr_b].
  - RD_LAT_B=2: an extra output register is added, and dout_b is the stage-1 value one clk_b later.
- Cross-port collision: a port B read of the address being written on the same effective instant returns either the old or the new word, never a mix of other bits. No other entry is affected.
- Port B reads during a clear return a mix of cleared and uncleared entries. This is legal.

## Timing
- Reset values: dout_a=0, busy=1, clear_done=0, dout_b=0 (once rst_b is asserted; reset must be held at least 3 clk_b cycles).
- Clear timeline, counting clk_a edges after reset falls:
  - Edge k (k=1..DEPTH) writes address k-1.
  - busy=0 and clear_done=1 after edge DEPTH.
  - clear_done=0 after edge DEPTH+1.
  - The first accepted write is sampled at edge DEPTH+1.
- A clear_req sampled at edge n writes address 0 at edge n+1. busy falls after edge n+DEPTH.
- Port A read latency is 1 clk_a cycle.
- Port B read latency is RD_LAT_B clk_b cycles from addr_b sample to dout_b.
- clk_a and clk_b are fully asynchronous. No handshake exists between the ports.

## Test plan
- Reset clear: defaults, reset held 4 cycles, then released → busy high for 16 cycles, clear_done pulses once after edge 16, and reading addresses 0..15 on port A returns 0.
- Write/read A: write 0xA to address 5, then read address 5 → dout_a=0xA one cycle later. Repeat a same-cycle write with new data 0x3 to address 5: WRITE_FIRST=0 gives 0xA, WRITE_FIRST=1 gives 0x3.
- Port B latency: write addresses 0..15 with value = address, clk_b unrelated to clk_a, sweep addr_b → dout_b equals the address after 1 cycle (RD_LAT_B=1) or 2 cycles (RD_LAT_B=2).
- Clear request: fill with 0xF, pulse clear_req, attempt a write of 0x7 to address 2 mid-clear, pulse a second clear_req → single clear_done pulse 16 cycles after the first request, and all entries equal INIT_VAL (including address 2).
- Collision priority: clear_req and a write of 0x9 to address 1 in the same cycle → address 1 reads INIT_VAL afterwards.
- Reset mid-clear: assert reset at cnt=8 → walk restarts at address 0, busy lasts 16 more cycles after release, dout_b is forced to 0 during rst_b, and ADDR_W=6/DATA_W=8 repeats the same checks with 64 clear cycles.

Source files
------------

// File: rtl/palette_ram_if.sv
// Bus bundle for palette_ram: CPU port A, clear control and the video read port B.
interface palette_ram_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] din_a;
  logic              we_n_a;
  logic [DATA_W-1:0] dout_a;
  logic              clear_req;
  logic              busy;
  logic              clear_done;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] dout_b;

  modport master (
    output addr_a, din_a, we_n_a, clear_req, addr_b,
    input  dout_a, busy, clear_done, dout_b
  );

  modport slave (
    input  addr_a, din_a, we_n_a, clear_req, addr_b,
    output dout_a, busy, clear_done, dout_b
  );
endinterface

// File: rtl/palette_ram.sv
// Dual-clock palette RAM. Port A (clk_a) is CPU read/write and owns the clear
// sequencer; port B (clk_b) is a read-only video port with 1 or 2 cycle latency.
//
// state | meaning
// IDLE  | normal CPU access on port A
// CLEAR | sequencer walking cnt over every entry writing INIT_VAL
module palette_ram #(
  parameter int                DATA_W      = 4,
  parameter int                ADDR_W      = 4,
  parameter logic [DATA_W-1:0] INIT_VAL    = '0,
  parameter int                RD_LAT_B    = 1,
  parameter int                WRITE_FIRST = 0
) (
  input  logic          clk_a,
  input  logic          reset,
  input  logic          clk_b,
  palette_ram_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DATA_W-1:0] ram [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              busy_q;
  logic              clear_done_q;
  logic [DATA_W-1:0] dout_a_q;

  logic              a_write;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;

  // A CPU write only lands in IDLE, and loses to a simultaneous clear request.
  assign a_write = (state == IDLE) && !bus.we_n_a && !bus.clear_req;

  // Single write port shared by the sequencer and the CPU.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = bus.addr_a;
    mem_din  = bus.din_a;
    if (!reset) begin
      if (state == CLEAR) begin
        mem_we   = 1'b1;
        mem_addr = cnt;
        mem_din  = INIT_VAL;
      end else if (a_write) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage write on clk_a; no reset so it maps onto block RAM.
  always_ff @(posedge clk_a) begin
    if (mem_we) ram[mem_addr] <= mem_din;
  end

  // Clear sequencer and registered port A read path.
  always_ff @(posedge clk_a) begin
    if (reset) begin
      state        <= CLEAR;
      cnt          <= '0;
      busy_q       <= 1'b1;
      clear_done_q <= 1'b0;
      dout_a_q     <= '0;
    end else begin
      clear_done_q <= 1'b0;
      case (state)
        CLEAR: begin
          cnt      <= cnt + ADDR_W'(1);
          dout_a_q <= INIT_VAL;
          if (cnt == LAST) begin
            state        <= IDLE;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b1;
          end
        end
        default: begin
          if (WRITE_FIRST != 0 && a_write) dout_a_q <= bus.din_a;
          else                             dout_a_q <= ram[bus.addr_a];
          if (bus.clear_req) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.dout_a     = dout_a_q;
  assign bus.busy       = busy_q;
  assign bus.clear_done = clear_done_q;

  logic              rst_meta;
  logic              rst_b;
  logic [DATA_W-1:0] rd_b1;

  // Bring reset into the clk_b domain through two flops.
  always_ff @(posedge clk_b) begin
    rst_meta <= reset;
    rst_b    <= rst_meta;
  end

  // Port B first read stage.
  always_ff @(posedge clk_b) begin
    if (rst_b) rd_b1 <= '0;
    else       rd_b1 <= ram[bus.addr_b];
  end

  generate
    if (RD_LAT_B == 2) begin : g_lat2
      logic [DATA_W-1:0] rd_b2;
      // Extra output register for the two-cycle latency build.
      always_ff @(posedge clk_b) begin
        if (rst_b) rd_b2 <= '0;
        else       rd_b2 <= rd_b1;
      end
      assign bus.dout_b = rd_b2;
    end else begin : g_lat1
      assign bus.dout_b = rd_b1;
    end
  endgenerate
endmodule

// File: tb/tb_palette_ram.sv
// Directed bench for palette_ram: three instances cover read-first/lat-1,
// write-first/lat-2 and a wide 64x8 build with a non-zero fill value.
module tb_palette_ram;
  logic clk_a = 1'b0;
  logic clk_b = 1'b0;
  logic reset = 1'b1;
  logic reset_w = 1'b1;

  always #5 clk_a = ~clk_a;
  always #7 clk_b = ~clk_b;

  palette_ram_if #(.DATA_W(4), .ADDR_W(4)) bus0 ();
  palette_ram_if #(.DATA_W(4), .ADDR_W(4)) bus1 ();
  palette_ram_if #(.DATA_W(8), .ADDR_W(6)) bus2 ();

  palette_ram #(.DATA_W(4), .ADDR_W(4), .INIT_VAL(4'h0), .RD_LAT_B(1), .WRITE_FIRST(0)) u_rf (
    .clk_a(clk_a), .reset(reset), .clk_b(clk_b), .bus(bus0));
  palette_ram #(.DATA_W(4), .ADDR_W(4), .INIT_VAL(4'h0), .RD_LAT_B(2), .WRITE_FIRST(1)) u_wf (
    .clk_a(clk_a), .reset(reset), .clk_b(clk_b), .bus(bus1));
  palette_ram #(.DATA_W(8), .ADDR_W(6), .INIT_VAL(8'h5A), .RD_LAT_B(1), .WRITE_FIRST(0)) u_wide (
    .clk_a(clk_a), .reset(reset_w), .clk_b(clk_b), .bus(bus2));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step_a();
    @(posedge clk_a);
    #1;
  endtask

  task automatic step_b();
    @(posedge clk_b);
    #1;
  endtask

  task automatic drive_a(input logic [3:0] addr, input logic [3:0] din, input logic we_n, input logic clr);
    bus0.addr_a = addr; bus0.din_a = din; bus0.we_n_a = we_n; bus0.clear_req = clr;
    bus1.addr_a = addr; bus1.din_a = din; bus1.we_n_a = we_n; bus1.clear_req = clr;
  endtask

  task automatic set_addr_b(input logic [3:0] a);
    bus0.addr_b = a;
    bus1.addr_b = a;
  endtask

  task automatic write_a(input logic [3:0] addr, input logic [3:0] din);
    drive_a(addr, din, 1'b0, 1'b0);
    step_a();
    drive_a(addr, din, 1'b1, 1'b0);
  endtask

  task automatic read_both(input string tag, input logic [3:0] addr, input logic [3:0] exp);
    drive_a(addr, 4'h0, 1'b1, 1'b0);
    step_a();
    check({tag, "_rf"}, bus0.dout_a, exp);
    check({tag, "_wf"}, bus1.dout_a, exp);
  endtask

  // Steps clk_a until busy drops; n is the edge count, or -1 if it never drops.
  task automatic wait_busy_fall(input bit wide, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      step_a();
      if (!(wide ? bus2.busy : bus0.busy)) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int pulses;
    int fall;

    drive_a(4'h0, 4'h0, 1'b1, 1'b0);
    set_addr_b(4'h0);
    bus2.addr_a = '0; bus2.din_a = '0; bus2.we_n_a = 1'b1; bus2.clear_req = 1'b0; bus2.addr_b = '0;

    // reset state
    repeat (8) step_a();
    check("rst_busy", bus0.busy, 1);
    check("rst_done", bus0.clear_done, 0);
    check("rst_dout_a", bus0.dout_a, 0);
    check("rst_dout_b_rf", bus0.dout_b, 0);
    check("rst_dout_b_wf", bus1.dout_b, 0);

    // power-up clear timeline
    reset = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      step_a();
      check($sformatf("clr_busy_%0d", k), bus0.busy, (k < 16) ? 1 : 0);
      if (bus0.clear_done) pulses++;
      if (k == 16) check("clr_done_16", bus0.clear_done, 1);
    end
    check("clr_pulses", pulses, 1);
    for (int i = 0; i < 16; i++) read_both($sformatf("clr_rd_%0d", i), 4'(i), 4'h0);

    // write then read, and read-during-write
    drive_a(4'h5, 4'hA, 1'b0, 1'b0);
    step_a();
    check("wr1_rdw_rf", bus0.dout_a, 4'h0);
    check("wr1_rdw_wf", bus1.dout_a, 4'hA);
    read_both("wr1_rd", 4'h5, 4'hA);
    drive_a(4'h5, 4'h3, 1'b0, 1'b0);
    step_a();
    check("wr2_rdw_rf", bus0.dout_a, 4'hA);
    check("wr2_rdw_wf", bus1.dout_a, 4'h3);
    read_both("wr2_rd", 4'h5, 4'h3);

    // port B latency sweep
    for (int i = 0; i < 16; i++) write_a(4'(i), 4'(i));
    for (int i = 0; i < 16; i++) begin
      step_b();
      set_addr_b(4'(i));
      step_b();
      check($sformatf("b_lat1_%0d", i), bus0.dout_b, i);
      check($sformatf("b_lat2_early_%0d", i), bus1.dout_b, (i == 0) ? 0 : i - 1);
      step_b();
      check($sformatf("b_lat2_%0d", i), bus1.dout_b, i);
    end

    // clear request with dropped write and ignored second request
    for (int i = 0; i < 16; i++) write_a(4'(i), 4'hF);
    read_both("fill_f", 4'h2, 4'hF);
    drive_a(4'h2, 4'h0, 1'b1, 1'b1);
    step_a();
    drive_a(4'h2, 4'h0, 1'b1, 1'b0);
    check("req_busy", bus0.busy, 1);
    pulses = 0;
    for (int j = 1; j <= 20; j++) begin
      if (j == 5)      drive_a(4'h2, 4'h7, 1'b0, 1'b0);
      else if (j == 8) drive_a(4'h2, 4'h0, 1'b1, 1'b1);
      else             drive_a(4'h2, 4'h0, 1'b1, 1'b0);
      step_a();
      check($sformatf("req_busy_%0d", j), bus0.busy, (j < 16) ? 1 : 0);
      if (j <= 16) check($sformatf("req_dout_a_%0d", j), bus0.dout_a, 0);
      if (bus0.clear_done) pulses++;
      if (j == 16) check("req_done_16", bus0.clear_done, 1);
    end
    check("req_pulses", pulses, 1);
    for (int i = 0; i < 16; i++) read_both($sformatf("req_rd_%0d", i), 4'(i), 4'h0);

    // clear request beats a same-cycle write
    write_a(4'h1, 4'h5);
    read_both("col_pre", 4'h1, 4'h5);
    drive_a(4'h1, 4'h9, 1'b0, 1'b1);
    step_a();
    check("col_dout_wf", bus1.dout_a, 4'h5);
    drive_a(4'h1, 4'h0, 1'b1, 1'b0);
    wait_busy_fall(1'b0, 40, fall);
    check("col_busy_len", fall, 16);
    read_both("col_rd", 4'h1, 4'h0);

    // reset in the middle of a clear
    for (int i = 0; i < 16; i++) write_a(4'(i), 4'hC);
    set_addr_b(4'hF);
    repeat (4) step_b();
    check("mid_pre_b_rf", bus0.dout_b, 4'hC);
    check("mid_pre_b_wf", bus1.dout_b, 4'hC);
    drive_a(4'h0, 4'h0, 1'b1, 1'b1);
    step_a();
    drive_a(4'h0, 4'h0, 1'b1, 1'b0);
    repeat (8) step_a();
    check("mid_busy", bus0.busy, 1);
    reset = 1'b1;
    repeat (8) step_a();
    check("mid_rst_b_rf", bus0.dout_b, 0);
    check("mid_rst_b_wf", bus1.dout_b, 0);
    check("mid_rst_busy", bus0.busy, 1);
    check("mid_rst_dout_a", bus0.dout_a, 0);
    reset = 1'b0;
    wait_busy_fall(1'b0, 40, fall);
    check("mid_busy_len", fall, 16);
    for (int i = 0; i < 16; i++) read_both($sformatf("mid_rd_%0d", i), 4'(i), 4'h0);

    // wide build: 64 entries, fill 0x5A
    check("w_rst_busy", bus2.busy, 1);
    check("w_rst_done", bus2.clear_done, 0);
    check("w_rst_dout_a", bus2.dout_a, 0);
    check("w_rst_dout_b", bus2.dout_b, 0);
    reset_w = 1'b0;
    wait_busy_fall(1'b1, 100, fall);
    check("w_busy_len", fall, 64);
    check("w_done", bus2.clear_done, 1);
    step_a();
    check("w_done_clr", bus2.clear_done, 0);
    for (int i = 0; i < 64; i += 21) begin
      bus2.addr_a = 6'(i);
      step_a();
      check($sformatf("w_rd_%0d", i), bus2.dout_a, 8'h5A);
    end
    bus2.addr_b = 6'd40;
    repeat (3) step_b();
    check("w_b_40", bus2.dout_b, 8'h5A);
    bus2.addr_a = 6'd63; bus2.din_a = 8'h3C; bus2.we_n_a = 1'b0;
    step_a();
    bus2.we_n_a = 1'b1;
    step_a();
    check("w_wr_63", bus2.dout_a, 8'h3C);
    bus2.addr_b = 6'd63;
    repeat (3) step_b();
    check("w_b_63", bus2.dout_b, 8'h3C);
    bus2.clear_req = 1'b1;
    step_a();
    bus2.clear_req = 1'b0;
    repeat (32) step_a();
    reset_w = 1'b1;
    repeat (8) step_a();
    check("w_mid_rst_b", bus2.dout_b, 0);
    check("w_mid_busy", bus2.busy, 1);
    reset_w = 1'b0;
    wait_busy_fall(1'b1, 100, fall);
    check("w_mid_busy_len", fall, 64);
    step_a();
    check("w_mid_rd_63", bus2.dout_a, 8'h5A);
    repeat (3) step_b();
    check("w_mid_b_63", bus2.dout_b, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
